// File: rtl/regfile_multiport.sv
// ============================================================================
// Module   : regfile_multiport
// Function : 3-read / 2-write register file with a sequenced bulk clear.
//            Optional write-to-read forwarding is enabled by REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ClearReq,
  output logic              Busy,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  input  logic [ADDR_W-1:0] ReadAddr3,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] ReadData3,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WA0,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [DATA_W-1:0] WD0,
  input  logic [DATA_W-1:0] WD1,
  output logic              WriteConflict
);

  localparam int              c_DEPTH    = 1 << ADDR_W;
  localparam logic            c_ZERO     = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] c_PTR_LAST = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic                r_conflict;
  logic [DATA_W-1:0]   r_mem [c_DEPTH];

  logic                w_busy;
  logic                w_we0;
  logic                w_we1;
  logic [ADDR_W-1:0]   w_raddr [3];

  assign w_busy = (r_state == CLEAR);
  // A write is only "real" if it survives the busy and zero-register filters.
  assign w_we0  = WE0 && !w_busy && !(c_ZERO && (WA0 == '0));
  assign w_we1  = WE1 && !w_busy && !(c_ZERO && (WA1 == '0));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (ClearReq) begin
          w_state_nxt = CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        if (r_ptr == c_PTR_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_ptr      <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_conflict <= w_we0 && w_we1 && (WA0 == WA1);
    end
  end

  // Storage is deliberately not reset; the clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_ptr] <= '0;
    end else begin
      if (w_we0) r_mem[WA0] <= WD0;
      if (w_we1) r_mem[WA1] <= WD1;
    end
  end

  assign w_raddr = '{ReadAddr1, ReadAddr2, ReadAddr3};

  for (genvar gi = 0; gi < 3; gi++) begin : g_rd
    logic [DATA_W-1:0] w_data;
    always_comb begin
      w_data = r_mem[w_raddr[gi]];
`ifdef REGFILE_BYPASS_EN
      if (w_we0 && (WA0 == w_raddr[gi])) w_data = WD0;
      if (w_we1 && (WA1 == w_raddr[gi])) w_data = WD1;
`endif
      if (c_ZERO && (w_raddr[gi] == '0)) w_data = '0;
      if (w_busy) w_data = '0;
    end
  end

  assign ReadData1     = g_rd[0].w_data;
  assign ReadData2     = g_rd[1].w_data;
  assign ReadData3     = g_rd[2].w_data;
  assign Busy          = w_busy;
  assign WriteConflict = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_regfile_multiport.sv
// ============================================================================
// Module   : tb_regfile_multiport
// Function : Self-checking bench for regfile_multiport against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_multiport;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic        ClearReq;
  logic        Busy;
  logic [4:0]  ReadAddr1, ReadAddr2, ReadAddr3;
  logic [31:0] ReadData1, ReadData2, ReadData3;
  logic        WE0, WE1;
  logic [4:0]  WA0, WA1;
  logic [31:0] WD0, WD1;
  logic        WriteConflict;

  regfile_multiport dut (
    .clk          (clk),
    .rst          (rst),
    .ClearReq     (ClearReq),
    .Busy         (Busy),
    .ReadAddr1    (ReadAddr1),
    .ReadAddr2    (ReadAddr2),
    .ReadAddr3    (ReadAddr3),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .ReadData3    (ReadData3),
    .WE0          (WE0),
    .WE1          (WE1),
    .WA0          (WA0),
    .WA1          (WA1),
    .WD0          (WD0),
    .WD1          (WD1),
    .WriteConflict(WriteConflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stored values, clear cycles still to run, conflict flag.
  logic [31:0] m_mem [DEPTH];
  int          m_left;
  logic        m_conf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (m_left > 0 || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (WE1 && WA1 == a) return WD1;
    if (WE0 && WA0 == a) return WD0;
`endif
    return m_mem[a];
  endfunction

  task automatic idle_inputs();
    ClearReq = 1'b0;
    WE0 = 1'b0; WE1 = 1'b0;
    WA0 = '0;   WA1 = '0;
    WD0 = '0;   WD1 = '0;
  endtask

  task automatic rand_inputs(input bit narrow, input int clear_odds);
    ReadAddr1 = 5'($urandom);
    ReadAddr2 = 5'($urandom);
    ReadAddr3 = 5'($urandom);
    WE0 = 1'($urandom);
    WE1 = 1'($urandom);
    WA0 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
    WA1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
    WD0 = $urandom;
    WD1 = $urandom;
    ClearReq = (clear_odds > 0) && ($urandom_range(1, clear_odds) == 1);
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic cycle();
    bit v0, v1;
    #1;
    chk("busy",     {31'd0, Busy},          {31'd0, (m_left > 0)});
    chk("conflict", {31'd0, WriteConflict}, {31'd0, m_conf});
    chk("rd1", ReadData1, exp_rd(ReadAddr1));
    chk("rd2", ReadData2, exp_rd(ReadAddr2));
    chk("rd3", ReadData3, exp_rd(ReadAddr3));
    @(posedge clk);
    v0 = WE0 && (m_left == 0) && (WA0 != 5'd0);
    v1 = WE1 && (m_left == 0) && (WA1 != 5'd0);
    if (m_left > 0) begin
      m_mem[DEPTH - m_left] = 32'd0;
      m_left--;
      m_conf = 1'b0;
    end else begin
      if (v0) m_mem[WA0] = WD0;
      if (v1) m_mem[WA1] = WD1;
      m_conf = v0 && v1 && (WA0 == WA1);
      if (ClearReq) m_left = DEPTH;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, Busy}, 32'd1);
    chk("rst_rd1",  ReadData1, 32'd0);
    chk("rst_conf", {31'd0, WriteConflict}, 32'd0);
    m_left = DEPTH;
    m_conf = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sweep();
    idle_inputs();
    for (int a = 0; a < DEPTH; a += 3) begin
      ReadAddr1 = 5'(a);
      ReadAddr2 = 5'(a + 1);
      ReadAddr3 = 5'(a + 2);
      cycle();
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    ReadAddr1 = '0; ReadAddr2 = '0; ReadAddr3 = '0;
    @(negedge clk);

    // Power-on clear: writes and clear requests during it must have no effect.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs(1'b0, 4);
      cycle();
    end
    sweep();

    // Basic write and zero-register behaviour.
    idle_inputs();
    WE0 = 1'b1; WA0 = 5'd5; WD0 = 32'hDEADBEEF;
    cycle();
    idle_inputs();
    ReadAddr2 = 5'd5;
    WE1 = 1'b1; WA1 = 5'd0; WD1 = 32'h1234;
    cycle();
    idle_inputs();
    ReadAddr1 = 5'd0;
    cycle();

    // Same-address dual write: port 1 wins, conflict pulses once.
    WE0 = 1'b1; WE1 = 1'b1; WA0 = 5'd7; WA1 = 5'd7; WD0 = 32'h11; WD1 = 32'h22;
    cycle();
    idle_inputs();
    ReadAddr1 = 5'd7;
    cycle();
    cycle();

    // Read of an address being written in the same cycle.
    WE0 = 1'b1; WA0 = 5'd9; WD0 = 32'hA5A5A5A5;
    ReadAddr3 = 5'd9;
    cycle();
    idle_inputs();
    cycle();

    // Randomised traffic with narrow addresses to provoke conflicts.
    for (int i = 0; i < 400; i++) begin
      rand_inputs(i % 2 == 0, 60);
      cycle();
    end
    idle_inputs();
    while (m_left > 0) cycle();

    // Fill, clear, write during clear, re-request mid-clear.
    for (int i = 1; i < DEPTH; i += 2) begin
      WE0 = 1'b1; WA0 = 5'(i);     WD0 = $urandom;
      WE1 = (i + 1 < DEPTH); WA1 = 5'(i + 1); WD1 = $urandom;
      cycle();
    end
    idle_inputs();
    ReadAddr1 = 5'd3;
    ClearReq = 1'b1;
    cycle();
    for (int k = 1; k <= DEPTH; k++) begin
      idle_inputs();
      ReadAddr1 = 5'd3;
      if (k == 2) begin WE0 = 1'b1; WA0 = 5'd3; WD0 = 32'hCAFEF00D; end
      if (k == 10) ClearReq = 1'b1;
      cycle();
    end
    idle_inputs();
    chk("clear_done", {31'd0, Busy}, 32'd0);
    sweep();

    // Reset in the middle of a clear restarts it from entry 0.
    for (int i = 1; i < DEPTH; i++) begin
      WE0 = 1'b1; WA0 = 5'(i); WD0 = $urandom;
      cycle();
    end
    idle_inputs();
    ClearReq = 1'b1;
    cycle();
    idle_inputs();
    for (int k = 0; k < 15; k++) cycle();
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      rand_inputs(1'b0, 0);
      cycle();
    end
    sweep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each register in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1: 1 makes entry 0 hardwired zero; 0 makes it an ordinary register.
REQ-004 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have ports: rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports: ClearReq  input  1  request a bulk clear of all entries.
REQ-007 SHALL have ports: Busy  output  1  high while a clear sequence runs.
REQ-008 SHALL have ports: ReadAddr1/2/3  input  ADDR_W each  three independent read addresses.
REQ-009 SHALL have ports: ReadData1/2/3  output  DATA_W each  combinational read data.
REQ-010 SHALL have ports: WE0, WE1  input  1 each  write enables for write ports 0 and 1.
REQ-011 SHALL have ports: WA0, WA1  input  ADDR_W each  write addresses.
REQ-012 SHALL have ports: WD0, WD1  input  DATA_W each  write data.
REQ-013 SHALL have ports: WriteConflict  output  1  registered flag, same-address dual write seen last cycle.

Function
REQ-014 Reads SHALL be combinational from ReadAddrN; no read latency.
REQ-015 Writes SHALL commit on the rising clk edge where WEn=1 and Busy=0; visible to reads the following cycle.
REQ-016 With ZERO_REG=1, reads of address 0 SHALL return 0 and writes to address 0 SHALL be dropped on either port.
REQ-017 With WE0=WE1=1 and WA0==WA1, port 1 SHALL win; WD0 is discarded.
REQ-018 WriteConflict SHALL be 1 for exactly the cycle after such a same-address dual write, else 0; a dropped write (Busy or zero reg) SHALL NOT count as conflict.
REQ-019 Clear FSM SHALL have states IDLE and CLEAR; Busy = (state==CLEAR).
REQ-020 IDLE->CLEAR on ClearReq=1 at a clock edge; clear pointer loads 0.
REQ-021 In CLEAR, each cycle SHALL write 0 to entry[ptr] and increment ptr; after entry DEPTH-1 is cleared, state SHALL return to IDLE (CLEAR lasts exactly DEPTH cycles).
REQ-022 ClearReq while Busy SHALL be ignored (no restart of pointer).
REQ-023 While Busy=1, WE0/WE1 SHALL be ignored and all ReadDataN SHALL return 0.
REQ-024 Pointer SHALL not wrap past DEPTH-1; no entry is cleared twice per sequence.

Reset
REQ-025 rst=1 SHALL asynchronously force state=CLEAR, ptr=0, WriteConflict=0, so Busy=1 and ReadDataN=0 immediately.
REQ-026 Array contents SHALL NOT be reset directly; after rst deasserts the clear sequence zeroes all DEPTH entries in DEPTH cycles.
REQ-027 rst asserted mid-clear or mid-operation SHALL restart the clear sequence from entry 0.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-029 Defined: if ReadAddrN equals an address being validly written this cycle, ReadDataN SHALL return that write data combinationally (port 1 data when both match); zero-reg and Busy rules still take precedence.
REQ-030 Undefined: ReadDataN SHALL return the stored value (pre-write) in the write cycle; no bypass logic is generated.

Verification
REQ-031 Pulse rst, release -> Busy=1 for exactly 32 cycles (defaults), ReadData1=0 throughout; afterwards all 32 entries read 0.
REQ-032 After idle: WE0=1 WA0=5 WD0=0xDEADBEEF -> next cycle ReadAddr2=5 gives 0xDEADBEEF; WE1=1 WA1=0 WD1=0x1234 -> ReadData of address 0 stays 0.
REQ-033 WE0=WE1=1, WA0=WA1=7, WD0=0x11, WD1=0x22 -> entry 7 = 0x22 next cycle, WriteConflict=1 for one cycle then 0.
REQ-034 Same cycle write WA0=9 WD0=0xA5A5A5A5 with ReadAddr3=9 -> ReadData3=0xA5A5A5A5 if REGFILE_BYPASS_EN, else old value (0).
REQ-035 Fill entries 1..31, assert ClearReq, attempt write to entry 3 during clear, re-pulse ClearReq at cycle 10 -> Busy stays 32 cycles total, write dropped, all entries 0 after.
REQ-036 Assert rst at cycle 15 of a clear -> Busy stays high, new sequence of 32 cycles begins at entry 0.
